// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared constants, grant encoding and credit helper for the RAM port arbiter
package ram_port_arbiter_pkg;

  localparam int RESP_FIFO_DEPTH = 2;
  localparam int RESP_CNT_W      = $clog2(RESP_FIFO_DEPTH + 1);

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

  // Reads in flight plus responses left after this cycle's pop must leave room for one more read.
  function automatic logic read_credit_ok(
    input logic                  inflight,
    input logic [RESP_CNT_W-1:0] occupancy,
    input logic                  pop
  );
    logic [RESP_CNT_W-1:0] load;
    load = RESP_CNT_W'(inflight) + occupancy - RESP_CNT_W'(pop);
    return load < RESP_CNT_W'(RESP_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_resp_fifo2.sv
// rtl/ram_port_arbiter_resp_fifo2.sv - two-entry valid/ready response FIFO
module resp_fifo2
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [RESP_CNT_W-1:0] o_count
);

  logic [DATA_WIDTH-1:0] r_mem [RESP_FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [RESP_CNT_W-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_in_ready  = (r_count < RESP_CNT_W'(RESP_FIFO_DEPTH));
  assign o_out_valid = (r_count != '0);
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Push and pop together leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + RESP_CNT_W'(1);
        2'b01:   r_count <= r_count - RESP_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin write/read arbiter for an external single-port RAM with a buffered read response
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 128,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [AW-1:0]         rd_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  gnt_e                  r_ptr;
  logic                  r_inflight;
  logic [RESP_CNT_W-1:0] w_fifo_count;
  logic                  w_fifo_in_ready;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_contested;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;

  assign w_pop    = resp_valid & resp_ready;
  assign w_credit = rst_n & read_credit_ok(r_inflight, w_fifo_count, w_pop);

  // A read starved of credit never blocks a write, whatever the pointer says.
  assign rd_ready = w_credit & (~wr_valid | (r_ptr == GNT_RD));
  assign wr_ready = rst_n & (~rd_valid | ~w_credit | (r_ptr == GNT_WR));

  assign w_wr_gnt    = wr_valid & wr_ready;
  assign w_rd_gnt    = rd_valid & rd_ready;
  assign w_contested = wr_valid & rd_valid & w_credit;

  assign ram_en   = w_wr_gnt | w_rd_gnt;
  assign ram_we   = w_wr_gnt;
  assign ram_addr = w_wr_gnt ? wr_addr : (w_rd_gnt ? rd_addr : '0);
  assign ram_din  = w_wr_gnt ? wr_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= GNT_WR;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_gnt;
      if (w_contested) begin
        r_ptr <= (r_ptr == GNT_WR) ? GNT_RD : GNT_WR;
      end
    end
  end

  // RAM read data lands one cycle after issue and is captured straight into the FIFO.
  resp_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (r_inflight & w_fifo_in_ready),
    .o_in_ready  (w_fifo_in_ready),
    .i_in_data   (ram_dout),
    .o_out_valid (resp_valid),
    .i_out_ready (resp_ready),
    .o_out_data  (resp_data),
    .o_count     (w_fifo_count)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter with a write-first RAM model
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, ram_addr;
  logic [DW-1:0] wr_data, resp_data, ram_din, ram_dout;
  logic          resp_valid, resp_ready, ram_en, ram_we;

  logic [DW-1:0] mem [128];
  bit            mem_init = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 + i;
      mem_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        ram_dout      <= ram_din;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 32'hDEAD_BEEF : 32'hA000_0000 + a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // reset state, valids asserted
    @(negedge clk); @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 7'd3; wr_data = 32'h1; rd_addr = 7'd4;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);

    // write 5 on first edge after release, read it back next cycle
    @(negedge clk);
    rst_n = 1'b1; rd_valid = 1'b0; wr_addr = 7'd5; wr_data = 32'hDEAD_BEEF;
    #1;
    chk("w5_wr_ready", wr_ready, 1);
    chk("w5_ram_we", ram_we, 1);
    chk("w5_ram_addr", ram_addr, 5);
    chk("w5_ram_din", ram_din, 32'hDEAD_BEEF);
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 7'd5; resp_ready = 1'b1;
    #1;
    chk("r5_rd_ready", rd_ready, 1);
    chk("r5_ram_en", ram_en, 1);
    chk("r5_ram_we", ram_we, 0);
    chk("r5_ram_addr", ram_addr, 5);
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    chk("r5_idle_en", ram_en, 0);
    chk("r5_lat1_valid", resp_valid, 0);
    @(negedge clk); #1;
    chk("r5_lat2_valid", resp_valid, 1);
    chk("r5_data", resp_data, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("r5_drained", resp_valid, 0);

    // contested round robin W,R,W,R
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 7'd10; wr_data = 32'h100 + k; rd_addr = 7'd20;
      #1;
      chk($sformatf("rr_we_%0d", k), ram_we, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_en_%0d", k), ram_en, 1);
      chk($sformatf("rr_addr_%0d", k), ram_addr, (k % 2 == 0) ? 10 : 20);
    end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk); #1;
    chk("rr_resp_valid", resp_valid, 1);
    chk("rr_resp_data", resp_data, 32'hA000_0014);
    @(negedge clk); #1;
    chk("rr_drained", resp_valid, 0);

    // credit exhaustion with resp_ready=0; write granted while pointer favours read
    @(negedge clk);
    resp_ready = 1'b0; wr_valid = 1'b1; wr_addr = 7'd31; wr_data = 32'h77; rd_valid = 1'b1; rd_addr = 7'd1;
    #1;
    chk("cr_contest_we", ram_we, 1);
    chk("cr_contest_rd_ready", rd_ready, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("cr_rd1_ready", rd_ready, 1);
    chk("cr_rd1_addr", ram_addr, 1);
    @(negedge clk);
    rd_addr = 7'd2;
    #1;
    chk("cr_rd2_ready", rd_ready, 1);
    @(negedge clk);
    rd_addr = 7'd3; wr_valid = 1'b1; wr_addr = 7'd30; wr_data = 32'h55;
    #1;
    chk("cr_rd3_denied", rd_ready, 0);
    chk("cr_wr_ready", wr_ready, 1);
    chk("cr_wr_we", ram_we, 1);
    chk("cr_wr_addr", ram_addr, 30);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("cr_full_rd_ready", rd_ready, 0);
    chk("cr_full_en", ram_en, 0);
    chk("cr_head1", resp_data, 32'hA000_0001);
    @(negedge clk);
    rd_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("cr_pop1", resp_data, 32'hA000_0001);
    @(negedge clk); #1;
    chk("cr_pop2_valid", resp_valid, 1);
    chk("cr_pop2", resp_data, 32'hA000_0002);
    @(negedge clk); #1;
    chk("cr_drained", resp_valid, 0);

    // streaming reads 0..7 at one per cycle
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      rd_valid = (j < 8); rd_addr = 7'(j);
      #1;
      if (j < 8) chk($sformatf("st_rd_ready_%0d", j), rd_ready, 1);
      if (j >= 2) begin
        chk($sformatf("st_valid_%0d", j), resp_valid, 1);
        chk($sformatf("st_data_%0d", j), resp_data, init_word(j - 2));
      end
    end
    @(negedge clk); #1;
    chk("st_drained", resp_valid, 0);

    // simultaneous push and pop at occupancy 1
    @(negedge clk);
    resp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 7'd6;
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 7'd7;
    #1;
    chk("pp_rd7_ready", rd_ready, 1);
    @(negedge clk);
    rd_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("pp_head6", resp_data, 32'hA000_0006);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("pp_valid_after", resp_valid, 1);
    chk("pp_head7", resp_data, 32'hA000_0007);
    chk("pp_occ1_rd_ready", rd_ready, 1);
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk); #1;
    chk("pp_drained", resp_valid, 0);

    // reset with one read in flight and one response buffered
    @(negedge clk);
    resp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 7'd1;
    @(negedge clk);
    rd_addr = 7'd2;
    @(negedge clk);
    rd_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_wr_ready", wr_ready, 0);
    chk("mr_rd_ready", rd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; resp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 7'd9; wr_data = 32'h99; rd_valid = 1'b1; rd_addr = 7'd9;
    #1;
    chk("mr_post_valid", resp_valid, 0);
    chk("mr_wr_first", wr_ready, 1);
    chk("mr_rd_wait", rd_ready, 0);
    chk("mr_we", ram_we, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("mr_rd9_ready", rd_ready, 1);
    chk("mr_post_valid2", resp_valid, 0);
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    chk("mr_post_valid3", resp_valid, 0);
    @(negedge clk); #1;
    chk("mr_r9_valid", resp_valid, 1);
    chk("mr_r9_data", resp_data, 32'h99);
    @(negedge clk); #1;
    chk("mr_drained", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
